// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a two-entry skid buffer between any two CPU stages.
// Carries NFIELD data fields plus a PC; req redirects to EXC_PC, flush inserts a bubble.
module pipe_stage_reg #(
    parameter int                 NFIELD = 7,
    parameter int                 WIDTH  = 32,
    parameter logic [WIDTH-1:0]   EXC_PC = 'h0000_4180,
    parameter int                 CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NFIELD*WIDTH-1:0]  in_data,
    input  logic [WIDTH-1:0]         in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NFIELD*WIDTH-1:0]  out_data,
    output logic [WIDTH-1:0]         out_pc,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         xfer_cnt
);

    localparam int DW = NFIELD * WIDTH;

    logic             out_valid_q, out_valid_n;
    logic [DW-1:0]    out_data_q,  out_data_n;
    logic [WIDTH-1:0] out_pc_q,    out_pc_n;
    logic             skid_valid_q, skid_valid_n;
    logic [DW-1:0]    skid_data_q,  skid_data_n;
    logic [WIDTH-1:0] skid_pc_q,    skid_pc_n;
    logic             in_ready_q,   in_ready_n;
    logic [CNT_W-1:0] xfer_cnt_q,   xfer_cnt_n;

    logic in_hs;
    logic out_hs;
    logic out_free;

    // in_ready is a register, so the input handshake never depends on out_ready combinationally
    assign in_hs    = in_valid && in_ready_q && !req && !flush;
    assign out_hs   = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_hs;

    always_comb begin
        out_valid_n  = out_valid_q;
        out_data_n   = out_data_q;
        out_pc_n     = out_pc_q;
        skid_valid_n = skid_valid_q;
        skid_data_n  = skid_data_q;
        skid_pc_n    = skid_pc_q;
        xfer_cnt_n   = xfer_cnt_q;

        if (req || flush) begin
            out_valid_n  = 1'b0;
            out_data_n   = '0;
            out_pc_n     = req ? EXC_PC : '0;
            skid_valid_n = 1'b0;
            skid_data_n  = '0;
            skid_pc_n    = '0;
        end else begin
            if (out_hs && (xfer_cnt_q != {CNT_W{1'b1}}))
                xfer_cnt_n = xfer_cnt_q + CNT_W'(1);

            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_n = 1'b1;
                    out_data_n  = skid_data_q;
                    out_pc_n    = skid_pc_q;
                    if (in_hs) begin
                        skid_valid_n = 1'b1;
                        skid_data_n  = in_data;
                        skid_pc_n    = in_pc;
                    end else begin
                        skid_valid_n = 1'b0;
                    end
                end else if (in_hs) begin
                    out_valid_n = 1'b1;
                    out_data_n  = in_data;
                    out_pc_n    = in_pc;
                end else begin
                    // an emptied OUT keeps its last data/PC so out_pc stays meaningful
                    out_valid_n = 1'b0;
                end
            end else if (in_hs) begin
                skid_valid_n = 1'b1;
                skid_data_n  = in_data;
                skid_pc_n    = in_pc;
            end
        end

        in_ready_n = !skid_valid_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
            xfer_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_n;
            out_data_q   <= out_data_n;
            out_pc_q     <= out_pc_n;
            skid_valid_q <= skid_valid_n;
            skid_data_q  <= skid_data_n;
            skid_pc_q    <= skid_pc_n;
            in_ready_q   <= in_ready_n;
            xfer_cnt_q   <= xfer_cnt_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_pc    = out_pc_q;
    assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a per-cycle vector table plus counter saturation and reset sequences.
module tb_pipe_stage_reg;

    localparam int NFIELD = 7;
    localparam int WIDTH  = 32;
    localparam int BW     = NFIELD * WIDTH;

    logic              clk;
    logic              reset;
    logic              req;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     in_data;
    logic [WIDTH-1:0]  in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     out_data;
    logic [WIDTH-1:0]  out_pc;
    logic [1:0]        occupancy;
    logic [15:0]       xfer_cnt;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [BW-1:0]     s_out_data;
    logic [WIDTH-1:0]  s_out_pc;
    logic [1:0]        s_occupancy;
    logic [3:0]        s_xfer_cnt;

    int passed = 0;
    int total  = 0;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
        .occupancy(occupancy), .xfer_cnt(xfer_cnt)
    );

    // narrow counter copy sharing the same stimulus, used for the saturation check
    pipe_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_pc(s_out_pc),
        .occupancy(s_occupancy), .xfer_cnt(s_xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        req;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [31:0] ipc;
        logic        ev;
        logic [31:0] epc;
        logic        ezero;
        logic        erdy;
        logic [1:0]  eocc;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [BW-1:0] dataOf(input logic [31:0] pc);
        logic [BW-1:0] d;
        for (int k = 0; k < NFIELD; k++)
            d[k*WIDTH +: WIDTH] = pc ^ (32'h1111_0000 * (k + 1));
        return d;
    endfunction

    task automatic addVec(input logic rst_n, input logic rq, input logic fl, input logic iv,
                          input logic ordy, input logic [31:0] ipc, input logic ev,
                          input logic [31:0] epc, input logic ezero, input logic erdy,
                          input logic [1:0] eocc, input logic [15:0] ecnt);
        vec_t v;
        v.rst_n = rst_n; v.req = rq; v.flush = fl; v.iv = iv; v.ordy = ordy; v.ipc = ipc;
        v.ev = ev; v.epc = epc; v.ezero = ezero; v.erdy = erdy; v.eocc = eocc; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rst_n, input logic rq, input logic fl,
                                 input logic iv, input logic ordy, input logic [31:0] ipc);
        @(negedge clk);
        reset     = rst_n;
        req       = rq;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = ipc;
        in_data   = dataOf(ipc);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    endtask

    initial begin
        logic [15:0] ecap;
        reset = 1'b0; req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_data = '0;

        // rst_n req fl iv ordy ipc | ov epc zero rdy occ cnt
        addVec(0, 0, 0, 1, 1, 32'h3000, 0, 32'h0,    1, 1, 0, 0);
        addVec(0, 1, 1, 1, 1, 32'h1234, 0, 32'h0,    1, 1, 0, 0);
        addVec(1, 0, 0, 1, 1, 32'h3000, 1, 32'h3000, 0, 1, 1, 0);
        addVec(1, 0, 0, 1, 1, 32'h3004, 1, 32'h3004, 0, 1, 1, 1);
        addVec(1, 0, 0, 1, 1, 32'h3008, 1, 32'h3008, 0, 1, 1, 2);
        addVec(1, 0, 0, 1, 1, 32'h300C, 1, 32'h300C, 0, 1, 1, 3);
        addVec(1, 0, 0, 0, 1, 32'h0,    0, 32'h300C, 0, 1, 0, 4);
        addVec(1, 0, 0, 1, 0, 32'h3000, 1, 32'h3000, 0, 1, 1, 4);
        addVec(1, 0, 0, 1, 0, 32'h3004, 1, 32'h3000, 0, 0, 2, 4);
        addVec(1, 0, 0, 1, 0, 32'h3008, 1, 32'h3000, 0, 0, 2, 4);
        addVec(1, 0, 0, 0, 1, 32'h0,    1, 32'h3004, 0, 1, 1, 5);
        addVec(1, 0, 0, 0, 1, 32'h0,    0, 32'h3004, 0, 1, 0, 6);
        addVec(1, 0, 0, 1, 0, 32'h3010, 1, 32'h3010, 0, 1, 1, 6);
        addVec(1, 0, 0, 1, 0, 32'h3014, 1, 32'h3010, 0, 0, 2, 6);
        addVec(1, 1, 0, 1, 1, 32'h3018, 0, 32'h4180, 1, 1, 0, 6);
        addVec(1, 0, 0, 1, 1, 32'h3020, 1, 32'h3020, 0, 1, 1, 6);
        addVec(1, 1, 1, 0, 1, 32'h0,    0, 32'h4180, 1, 1, 0, 6);
        addVec(1, 0, 0, 1, 0, 32'h3024, 1, 32'h3024, 0, 1, 1, 6);
        addVec(1, 0, 1, 1, 1, 32'h3028, 0, 32'h0,    1, 1, 0, 6);
        addVec(1, 0, 0, 1, 1, 32'h302C, 1, 32'h302C, 0, 1, 1, 6);
        addVec(0, 0, 0, 1, 1, 32'h3030, 0, 32'h0,    1, 1, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].ipc);
            checkOutput($sformatf("v%0d out_valid", i), BW'(out_valid), BW'(vecs[i].ev));
            checkOutput($sformatf("v%0d out_pc", i),    BW'(out_pc),    BW'(vecs[i].epc));
            checkOutput($sformatf("v%0d out_data", i),  out_data,
                        vecs[i].ezero ? '0 : dataOf(vecs[i].epc));
            checkOutput($sformatf("v%0d in_ready", i),  BW'(in_ready),  BW'(vecs[i].erdy));
            checkOutput($sformatf("v%0d occupancy", i), BW'(occupancy), BW'(vecs[i].eocc));
            checkOutput($sformatf("v%0d xfer_cnt", i),  BW'(xfer_cnt),  BW'(vecs[i].ecnt));
            ecap = (vecs[i].ecnt > 16'd15) ? 16'd15 : vecs[i].ecnt;
            checkOutput($sformatf("v%0d sat xfer_cnt", i), BW'(s_xfer_cnt), BW'(ecap));
        end

        // reset dominates whatever else is on the inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), $urandom);
            checkOutput($sformatf("rnd%0d out_valid", i), BW'(out_valid), BW'(1'b0));
            checkOutput($sformatf("rnd%0d out_pc", i),    BW'(out_pc),    BW'(32'h0));
            checkOutput($sformatf("rnd%0d out_data", i),  out_data,       '0);
            checkOutput($sformatf("rnd%0d in_ready", i),  BW'(in_ready),  BW'(1'b1));
            checkOutput($sformatf("rnd%0d occupancy", i), BW'(occupancy), BW'(2'd0));
            checkOutput($sformatf("rnd%0d xfer_cnt", i),  BW'(xfer_cnt),  BW'(16'd0));
        end

        // 21 streaming cycles: first loads OUT, the remaining 20 are output handshakes
        for (int i = 0; i < 21; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5000 + 32'(4 * i));
        checkOutput("sat cnt after 20", BW'(s_xfer_cnt), BW'(4'd15));
        checkOutput("wide cnt after 20", BW'(xfer_cnt), BW'(16'd20));
        checkOutput("stream last pc", BW'(out_pc), BW'(32'h5050));

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h6000);
        checkOutput("sat cnt after req", BW'(s_xfer_cnt), BW'(4'd15));
        checkOutput("wide cnt after req", BW'(xfer_cnt), BW'(16'd20));
        checkOutput("req out_pc", BW'(out_pc), BW'(32'h4180));

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("sat cnt after reset", BW'(s_xfer_cnt), BW'(4'd0));
        checkOutput("wide cnt after reset", BW'(xfer_cnt), BW'(16'd0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
